fwd_hazard_unit: RTL

//  Parametrised operand-forwarding and hazard unit for the pipelined RV core. Drives per-source bypass

---
 rtl/hazard_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 47 ++++
 rtl/fwd_hazard_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared widths, types and producer latencies for the operand-forwarding /
// hazard logic of the pipelined RV core.
package hazard_pkg;

    localparam int REG_AW  = 5;
    localparam int MAX_LAT = 4;
    localparam int LW      = $clog2(MAX_LAT + 1);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [LW-1:0]     lat_t;

    // Cycles until a producer's result is visible at the EX/MEM output.
    localparam lat_t LAT_ALU  = lat_t'(1);
    localparam lat_t LAT_LOAD = lat_t'(2);

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register latency scoreboard. Each architectural register r >= 1 owns a
// down-counter holding the cycles left until its pending result reaches a
// bypass point. x0 is never tracked and always reads back as 0.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = hazard_pkg::REG_AW,
    parameter int LW      = hazard_pkg::LW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_en,
    input  logic [REG_AW-1:0]         set_rd,
    input  logic [LW-1:0]             set_lat,
    input  logic [NUM_SRC*REG_AW-1:0] rd_addr,
    output logic [NUM_SRC*LW-1:0]     rd_cnt
);

    localparam int NREG = 1 << REG_AW;

    logic [LW-1:0] cnt [NREG];

    // Load a new latency on issue (the set beats a same-cycle decrement),
    // otherwise count every busy register down; cnt[0] stays at its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (set_en && (set_rd == REG_AW'(r))) begin
                    cnt[r] <= set_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LW'(1);
                end
            end
        end
    end

    // One combinational read port per source operand.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_rd
        assign rd_cnt[s*LW +: LW] = cnt[rd_addr[s*REG_AW +: REG_AW]];
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and hazard unit. Picks the youngest matching bypass stage
// for each EX source, stalls ID while a multi-cycle producer has not yet reached
// a bypass point, and counts stall cycles with a saturating counter.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int REG_AW   = hazard_pkg::REG_AW,
    parameter int MAX_LAT  = hazard_pkg::MAX_LAT,
    parameter int STALL_CW = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]                id_rs,
    input  logic [NUM_SRC-1:0]                       id_rs_used,
    input  logic [REG_AW-1:0]                        id_rd,
    input  logic                                     id_reg_write,
    input  logic [$clog2(MAX_LAT+1)-1:0]             id_lat,
    input  logic                                     flush,
    input  logic [NUM_SRC*REG_AW-1:0]                ex_rs,
    input  logic [NUM_FWD*REG_AW-1:0]                fwd_rd,
    input  logic [NUM_FWD-1:0]                       fwd_we,
    output logic [NUM_SRC*$clog2(NUM_FWD+1)-1:0]     fwd_sel,
    output logic                                     stall,
    output logic [STALL_CW-1:0]                      stall_cycles
);

    localparam int LW  = $clog2(MAX_LAT + 1);
    localparam int FSW = $clog2(NUM_FWD + 1);

    logic [NUM_SRC*LW-1:0] src_cnt;
    logic [NUM_SRC-1:0]    src_busy;
    logic                  set_en;
    logic [LW-1:0]         lat_eff;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [REG_AW-1:0] rs;
        logic [FSW-1:0]    sel;

        assign rs = ex_rs[s*REG_AW +: REG_AW];

        // Priority encode: scanning oldest to youngest lets the youngest match win.
        always_comb begin
            sel = '0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_we[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
                    (fwd_rd[k*REG_AW +: REG_AW] == rs)) begin
                    sel = FSW'(k + 1);
                end
            end
        end

        assign fwd_sel[s*FSW +: FSW] = sel;

        // A source blocks ID only while its producer is more than one cycle away.
        assign src_busy[s] = id_rs_used[s] && (id_rs[s*REG_AW +: REG_AW] != '0) &&
                             (src_cnt[s*LW +: LW] > LW'(1));
    end

    assign stall  = id_valid && !flush && (|src_busy);
    assign set_en = id_valid && !stall && !flush && id_reg_write && (id_rd != '0);

    // Clamp the producer latency into 1..MAX_LAT.
    always_comb begin
        lat_eff = id_lat;
        if (id_lat == '0) begin
            lat_eff = LW'(LAT_ALU);
        end else if (id_lat > LW'(MAX_LAT)) begin
            lat_eff = LW'(MAX_LAT);
        end
    end

    reg_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .REG_AW  (REG_AW),
        .LW      (LW)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_rd  (id_rd),
        .set_lat (lat_eff),
        .rd_addr (id_rs),
        .rd_cnt  (src_cnt)
    );

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CW'(1);
        end
    end

endmodule
